// File: rtl/bit_serial_alu_if.sv
// Handshake and operand/result bundle for bit_serial_alu.
// master = issuing controller, slave = the ALU front end.
interface bit_serial_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport master (output start, op, a, b, input busy, done, result, carry_out);
  modport slave  (input start, op, a, b, output busy, done, result, carry_out);
endinterface

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU front end: feeds one operand bit pair per clock (LSB first)
// to 1-bit AND/OR/adder slices and shifts the slice result back into a word.
// Optional feature macro: BIT_SERIAL_ALU_SUB_EN (op=11 performs a-b; when
// undefined, op=11 aliases ADD).
module bit_serial_alu #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  bit_serial_alu_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh, b_sh, res_q;
  logic [1:0]       op_q;
  logic             c_q, cout_q;
  logic             accept, last;
  logic             bit_a, bit_b, bit_r, c_nxt;
  logic             busy_d, done_d;

  assign accept = bus.start && (state_q == S_IDLE || state_q == S_DONE);
  assign last   = (cnt_q == CW'(WIDTH - 1));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state: start is only honoured outside RUN; DONE may chain directly into RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last)      state_d = S_DONE;
      S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs decode straight from the state register, so nothing combinational reaches them from inputs
  always_comb begin
    busy_d = (state_q == S_RUN);
    done_d = (state_q == S_DONE);
  end

  assign bus.busy      = busy_d;
  assign bus.done      = done_d;
  assign bus.result    = res_q;
  assign bus.carry_out = cout_q;

  // 1-bit slice: subtraction is a + ~b + 1, so b is inverted and carry preset to 1
  always_comb begin
    bit_a = a_sh[0];
`ifdef BIT_SERIAL_ALU_SUB_EN
    bit_b = b_sh[0] ^ (op_q == 2'b11);
`else
    bit_b = b_sh[0];
`endif
    case (op_q)
      2'b00:   bit_r = bit_a & bit_b;
      2'b01:   bit_r = bit_a | bit_b;
      default: bit_r = bit_a ^ bit_b ^ c_q;
    endcase
    c_nxt = op_q[1] ? ((bit_a & bit_b) | (bit_a & c_q) | (bit_b & c_q)) : 1'b0;
  end

  // operand capture, serial shifting and result collection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_q  <= '0;
      op_q   <= 2'b00;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      cnt_q  <= '0;
    end else if (accept) begin
      a_sh   <= bus.a;
      b_sh   <= bus.b;
      op_q   <= bus.op;
      res_q  <= '0;
      cout_q <= 1'b0;
      cnt_q  <= '0;
`ifdef BIT_SERIAL_ALU_SUB_EN
      c_q    <= (bus.op == 2'b11);
`else
      c_q    <= 1'b0;
`endif
    end else if (state_q == S_RUN) begin
      a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
      res_q <= {bit_r, res_q[WIDTH-1:1]};
      c_q   <= c_nxt;
      cnt_q <= cnt_q + CW'(1);
      if (last) cout_q <= c_nxt;
    end
  end
endmodule

// File: tb/tb_bit_serial_alu.sv
// Randomized self-checking bench for bit_serial_alu (WIDTH=8 and WIDTH=32 instances).
module tb_bit_serial_alu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bit_serial_alu_if #(.WIDTH(8))  if8 ();
  bit_serial_alu_if #(.WIDTH(32)) if32 ();

  bit_serial_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  bit_serial_alu #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: whole-word arithmetic, {carry, result}
  function automatic logic [32:0] model(input int w, input logic [1:0] o,
                                        input logic [31:0] x, input logic [31:0] y);
    logic [63:0] m, s;
    m = (64'd1 << w) - 64'd1;
    case (o)
      2'b00: s = {32'd0, x & y};
      2'b01: s = {32'd0, x | y};
      2'b10: s = {32'd0, x} + {32'd0, y};
      default: begin
`ifdef BIT_SERIAL_ALU_SUB_EN
        s = {32'd0, x} + ((~{32'd0, y}) & m) + 64'd1;
`else
        s = {32'd0, x} + {32'd0, y};
`endif
      end
    endcase
    model = {(o[1] ? s[w] : 1'b0), s[31:0] & m[31:0]};
  endfunction

  // called #1 after the accept edge; counts edges until done shows
  task automatic wait_done8(output int cyc, output int nb);
    cyc = 0; nb = 0;
    while (!if8.done && cyc < 200) begin
      if (if8.busy) nb++;
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic run8(input string tag, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      output logic [7:0] r, output logic c);
    int cyc, nb;
    logic [32:0] e;
    @(negedge clk);
    if8.start = 1'b1; if8.op = o; if8.a = x; if8.b = y;
    @(posedge clk); #1;
    if8.start = 1'b0;
    if8.a = 8'($urandom); if8.b = 8'($urandom); if8.op = 2'($urandom);
    wait_done8(cyc, nb);
    check({tag, "_lat"}, cyc, 8);
    check({tag, "_busy"}, nb, 8);
    r = if8.result; c = if8.carry_out;
    e = model(8, o, {24'd0, x}, {24'd0, y});
    check({tag, "_res"}, r, e[7:0]);
    check({tag, "_cy"}, c, e[32]);
    @(posedge clk); #1;
    check({tag, "_done1"}, if8.done, 0);
    check({tag, "_hold"}, if8.result, e[7:0]);
  endtask

  task automatic run32(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int cyc;
    logic [32:0] e;
    @(negedge clk);
    if32.start = 1'b1; if32.op = o; if32.a = x; if32.b = y;
    @(posedge clk); #1;
    if32.start = 1'b0; if32.a = $urandom; if32.b = $urandom;
    cyc = 0;
    while (!if32.done && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    e = model(32, o, x, y);
    check({tag, "_lat"}, cyc, 32);
    check({tag, "_res"}, if32.result, e[31:0]);
    check({tag, "_cy"}, if32.carry_out, e[32]);
  endtask

  initial begin
    logic [7:0] r;
    logic c;
    int cyc, nb, seen;
    rst = 1'b1;
    if8.start = 0; if8.op = 0; if8.a = 0; if8.b = 0;
    if32.start = 0; if32.op = 0; if32.a = 0; if32.b = 0;
    #1;
    check("rst_busy", if8.busy, 0);
    check("rst_done", if8.done, 0);
    check("rst_res", if8.result, 0);
    check("rst_cy", if8.carry_out, 0);
    check("rst_res32", if32.result, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // directed vectors with hand-computed results
    run8("or", 2'b01, 8'hA5, 8'h0F, r, c);
    check("tp_or", {c, r}, {1'b0, 8'hAF});
    run8("and", 2'b00, 8'hF0, 8'h3C, r, c);
    check("tp_and", {c, r}, {1'b0, 8'h30});
    run8("add", 2'b10, 8'hFF, 8'h01, r, c);
    check("tp_add", {c, r}, {1'b1, 8'h00});
    run8("sub1", 2'b11, 8'h05, 8'h07, r, c);
`ifdef BIT_SERIAL_ALU_SUB_EN
    check("tp_sub1", {c, r}, {1'b0, 8'hFE});
    run8("sub2", 2'b11, 8'h07, 8'h05, r, c);
    check("tp_sub2", {c, r}, {1'b1, 8'h02});
`else
    check("tp_sub1", {c, r}, {1'b0, 8'h0C});
`endif

    // start pulse mid-RUN is ignored, then start held through DONE chains the next op
    @(negedge clk);
    if8.start = 1'b1; if8.op = 2'b01; if8.a = 8'hA5; if8.b = 8'h0F;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if8.start = 1'b1; if8.op = 2'b00; if8.a = 8'h11; if8.b = 8'h22;
    @(posedge clk); #1;
    check("mid_busy", if8.busy, 1);
    if8.start = 1'b0;
    @(negedge clk);
    if8.start = 1'b1; if8.op = 2'b10; if8.a = 8'hFF; if8.b = 8'h01;
    wait_done8(cyc, nb);
    check("mid_res", if8.result, 8'hAF);
    check("mid_cy", if8.carry_out, 0);
    @(posedge clk); #1;
    check("b2b_busy", if8.busy, 1);
    check("b2b_done", if8.done, 0);
    check("b2b_clr", {if8.carry_out, if8.result}, 0);
    if8.start = 1'b0;
    wait_done8(cyc, nb);
    check("b2b_lat", cyc, 8);
    check("b2b_res", {if8.carry_out, if8.result}, {1'b1, 8'h00});

    // asynchronous reset while bit 3 is in flight
    @(negedge clk);
    if8.start = 1'b1; if8.op = 2'b10; if8.a = 8'h7B; if8.b = 8'h96;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("ar_busy", if8.busy, 0);
    check("ar_done", if8.done, 0);
    check("ar_res", if8.result, 0);
    check("ar_cy", if8.carry_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (if8.done || if8.busy) seen++;
    end
    check("ar_quiet", seen, 0);
    run8("ar_after", 2'b10, 8'h7B, 8'h96, r, c);

    // randomized operations
    for (int i = 0; i < 24; i++)
      run8("rnd8", 2'($urandom), 8'($urandom), 8'($urandom), r, c);

    // full width
    run32("w32", 2'b10, 32'hFFFF_FFFF, 32'h0000_0001);
    check("w32_tp", {if32.carry_out, if32.result}, {1'b1, 32'h0});
    for (int i = 0; i < 4; i++)
      run32("rnd32", 2'($urandom), $urandom, $urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bit_serial_alu.md
# bit_serial_alu

Bit-serial ALU front end that feeds the 1-bit logic/arithmetic slices one operand bit pair per clock, LSB first, and collects the slice outputs into a parallel result word. It sits directly upstream of the 1-bit OR/AND/adder slices: it registers both operands, presents bit *i* of each operand to the slices on cycle *i*, and shifts each slice result back in. It provides a start/busy/done handshake so a controller can issue one operation at a time.

## Interface
- WIDTH, 32, operand and result width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- op  input  2  operation select: 00 AND, 01 OR, 10 ADD, 11 SUB.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  WIDTH  result word; held until the next accepted start.
- carry_out  output  1  final carry for ADD/SUB; 0 for AND/OR.

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - capture a, b, op into internal shift registers; clear the bit counter.
  - Set the serial carry to 1 if op=SUB, otherwise 0.
  - Go to RUN.
- RUN, each cycle:
  - Slice inputs are a_sh[0] and b_sh[0]; for SUB, the b bit is inverted.
  - Bit result: AND = a&b, OR = a|b, ADD/SUB = a^b'^c.
  - New carry = majority(a, b', c) for ADD/SUB; held at 0 for AND/OR.
  - Shift a_sh and b_sh right by 1. Shift result right by 1 with the new bit inserted at the MSB. Increment the counter.
- RUN exits to DONE after the cycle that processes bit WIDTH-1 (counter = WIDTH-1).
- DONE lasts exactly one cycle, then goes to IDLE unless start=1 (back-to-back issue).
- start is ignored in RUN. Changes on a, b, or op during RUN have no effect.
- carry_out is registered from the serial carry on RUN exit.
  - SUB: carry_out=1 means no borrow (a ≥ b unsigned).
- result and carry_out are cleared on an accepted start.

## Timing
- Reset (asynchronous, any state, including mid-RUN): state IDLE, busy=0, done=0, result=0, carry_out=0, counter=0, operand registers=0. No done pulse follows a reset.
- Start is accepted on edge E0. busy=1 from after E0 through edge E(WIDTH).
- Bits 0..WIDTH-1 are processed on edges E1..E(WIDTH).
- After E(WIDTH): busy=0, done=1, result and carry_out valid. The latency from the start edge to valid result is WIDTH+1 edges (33 for WIDTH=32).
- done is high for exactly one cycle.
- Start held high through DONE: the next operation is accepted on edge E(WIDTH+1). busy reasserts with no IDLE gap, and result/carry_out clear on that edge.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Configuration
- BIT_SERIAL_ALU_SUB_EN defined:
  - op=11 performs SUB (a + ~b + 1) as described above.
- BIT_SERIAL_ALU_SUB_EN not defined:
  - The b inversion and carry preset logic are removed.
  - op=11 behaves exactly as ADD: result = a+b, carry_out = carry from a+b.

## Test plan
- WIDTH=8, op=01, a=8'hA5, b=8'h0F → after 9 edges: result=8'hAF, carry_out=0; done high for exactly 1 cycle; busy high for 8 cycles.
- WIDTH=8, op=00, a=8'hF0, b=8'h3C → result=8'h30, carry_out=0. Then op=10, a=8'hFF, b=8'h01 → result=8'h00, carry_out=1.
- WIDTH=8, op=11, a=8'h05, b=8'h07 → with the macro: result=8'hFE, carry_out=0. Without the macro: result=8'h0C, carry_out=0. Also with the macro, a=8'h07, b=8'h05 → result=8'h02, carry_out=1.
- Pulse start again 3 cycles into RUN with different a/b → ignored; the original result is produced.
  - Then hold start high through DONE → the second op is accepted on the DONE edge, and busy reasserts on the next cycle.
- Assert rst asynchronously (mid-cycle) while processing bit 3 → busy, done, result, and carry_out go to 0 immediately; no done pulse follows.
  - A subsequent start completes normally with correct values.
- WIDTH=32, op=10, a=32'hFFFF_FFFF, b=32'h0000_0001 → after 33 edges: result=0, carry_out=1.
